sqrt_bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the square-root stage. It takes the 20-bit binary root result and produces 6 packed BCD digits for the display/readout stage. It uses the shift-and-add-3 (double-dabble) method, one bit per clock, with a start/busy/done handshake.

---
 rtl/sqrt_bin2bcd_seq_pkg.sv | 24 ++
 rtl/sqrt_bin2bcd_seq_bcd_add3_digit.sv | 20 ++
 rtl/sqrt_bin2bcd_seq.sv | 130 +++++++++++++
 tb/tb_sqrt_bin2bcd_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_bin2bcd_seq_pkg.sv
// Shared constants, state encoding and decimal-limit helper for the
// sequential binary-to-BCD converter.
package sqrt_bin2bcd_seq_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BIN_W_DEF   = 20;
  localparam int DIGITS_DEF  = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Largest value representable in the given number of decimal digits (10^digits - 1).
  function automatic logic [63:0] bcd_limit(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/sqrt_bin2bcd_seq_bcd_add3_digit.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import sqrt_bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Add 3 to digits >= 5, pass smaller digits unchanged.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/sqrt_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with start/busy/done handshake. Overflow is decided up front from the
// input value; the displayed result saturates to all nines in that case.
module sqrt_bin2bcd_seq
  import sqrt_bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [63:0] LIMIT = bcd_limit(DIGITS);
  localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [BIN_W-1:0]   shift_r, shift_nxt_s;
  logic [ACC_W-1:0]   acc_r, acc_nxt_s;
  logic               ovf_flag_r, ovf_flag_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic [ACC_W-1:0]   bcd_out_r, bcd_out_nxt_s;
  logic               ovf_r, ovf_nxt_s;

  logic [ACC_W-1:0]   acc_adj_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic               over_s;

  // Per-digit add-3 correction applied to the accumulator before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .din  (acc_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (acc_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The corrected accumulator shifts left, taking the binary MSB into the units LSB;
  // the carry out of the top digit is dropped (covered by the overflow flag).
  assign acc_shift_s = {acc_adj_s[ACC_W-2:0], shift_r[BIN_W-1]};

  // Input exceeds what DIGITS decimal digits can show.
  assign over_s = ({{(64-BIN_W){1'b0}}, bin_in} > LIMIT);

  // Next-state and datapath update for the IDLE/CONV sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    shift_nxt_s    = shift_r;
    acc_nxt_s      = acc_r;
    ovf_flag_nxt_s = ovf_flag_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
    bcd_out_nxt_s  = bcd_out_r;
    ovf_nxt_s      = ovf_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s    = CONV;
          shift_nxt_s    = bin_in;
          acc_nxt_s      = {ACC_W{1'b0}};
          cnt_nxt_s      = {CNT_W{1'b0}};
          ovf_flag_nxt_s = over_s;
          busy_nxt_s     = 1'b1;
        end else begin
          busy_nxt_s     = 1'b0;
        end
      end
      CONV: begin
        acc_nxt_s   = acc_shift_s;
        shift_nxt_s = {shift_r[BIN_W-2:0], 1'b0};
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_CNT) begin
          state_nxt_s   = IDLE;
          busy_nxt_s    = 1'b0;
          done_nxt_s    = 1'b1;
          bcd_out_nxt_s = ovf_flag_r ? ALL_NINES : acc_shift_s;
          ovf_nxt_s     = ovf_flag_r;
        end else begin
          busy_nxt_s    = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      shift_r    <= {BIN_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      ovf_flag_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_out_r  <= {ACC_W{1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      acc_r      <= acc_nxt_s;
      ovf_flag_r <= ovf_flag_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      bcd_out_r  <= bcd_out_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bcd_out = bcd_out_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_sqrt_bin2bcd_seq.sv
// Self-checking bench for sqrt_bin2bcd_seq: directed vector table, random
// values against a decimal reference model, and handshake corner cases.
module tb_sqrt_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  sqrt_bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: decimal digits by plain division, saturating above 999999.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = 24'h0;
    x = v;
    if (v > 32'd999999) return 24'h999999;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Called at a negedge: hold start for exactly one rising edge, then scramble bin_in.
  task automatic pulse_start(input logic [19:0] v);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 20'($urandom);
  endtask

  // Called at the negedge after the accepting edge. Counts edges until done,
  // checking busy stays high and bcd_out stays put; optionally injects a start.
  task automatic wait_done(input int inj_at, input logic [19:0] inj_v,
                           output int lat, output logic busy_ok, output logic held_ok);
    logic [23:0] held;
    held    = bcd_out;
    lat     = 0;
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    held_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (lat == inj_at) begin
        start  = 1'b1;
        bin_in = inj_v;
      end else begin
        start  = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (done !== 1'b1) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (bcd_out !== held) held_ok = 1'b0;
      end else begin
        if (busy !== 1'b0) busy_ok = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  vec_t        vecs[9];
  int          lat;
  logic        busy_ok, held_ok;
  int          dcount;
  logic [19:0] rv;

  initial begin
    vecs[0] = '{20'd0,       24'h000000, 1'b0};
    vecs[1] = '{20'd999,     24'h000999, 1'b0};
    vecs[2] = '{20'd1000,    24'h001000, 1'b0};
    vecs[3] = '{20'd999999,  24'h999999, 1'b0};
    vecs[4] = '{20'd1048575, 24'h999999, 1'b1};
    vecs[5] = '{20'd1000000, 24'h999999, 1'b1};
    vecs[6] = '{20'd12345,   24'h012345, 1'b0};
    vecs[7] = '{20'd65536,   24'h065536, 1'b0};
    vecs[8] = '{20'd42,      24'h000042, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = 20'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_bcd",  {8'd0, bcd_out}, 32'd0);
    chk("reset_ovf",  {31'd0, ovf}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      pulse_start(vecs[i].bin);
      wait_done(-1, 20'd0, lat, busy_ok, held_ok);
      chk("vec_latency", lat, 32'd20);
      chk("vec_bcd", {8'd0, bcd_out}, {8'd0, vecs[i].bcd});
      chk("vec_ovf", {31'd0, ovf}, {31'd0, vecs[i].ovf});
      chk("vec_busy", {31'd0, busy_ok}, 32'd1);
      chk("vec_held", {31'd0, held_ok}, 32'd1);
      @(negedge clk);
      chk("vec_done_width", {31'd0, done}, 32'd0);
      chk("vec_bcd_hold", {8'd0, bcd_out}, {8'd0, vecs[i].bcd});
    end

    // Random values against the decimal model; bias some toward the limit.
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0) rv = 20'($urandom_range(999990, 1000010));
      else            rv = 20'($urandom_range(0, 1048575));
      pulse_start(rv);
      wait_done(-1, 20'd0, lat, busy_ok, held_ok);
      chk("rnd_latency", lat, 32'd20);
      chk("rnd_bcd", {8'd0, bcd_out}, {8'd0, ref_bcd(32'(rv))});
      chk("rnd_ovf", {31'd0, ovf}, {31'd0, (32'(rv) > 32'd999999)});
      chk("rnd_busy", {31'd0, busy_ok}, 32'd1);
      @(negedge clk);
    end

    // Start while busy is ignored; exactly one done pulse follows.
    pulse_start(20'd12345);
    wait_done(5, 20'd777, lat, busy_ok, held_ok);
    chk("ign_latency", lat, 32'd20);
    chk("ign_bcd", {8'd0, bcd_out}, 32'h00012345);
    chk("ign_busy", {31'd0, busy_ok}, 32'd1);
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("ign_extra_done", dcount, 32'd0);
    chk("ign_idle_busy", {31'd0, busy}, 32'd0);

    // Reset mid-conversion aborts it with no done pulse.
    pulse_start(20'd65536);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bcd",  {8'd0, bcd_out}, 32'd0);
    chk("abort_ovf",  {31'd0, ovf}, 32'd0);
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("abort_quiet", dcount, 32'd0);
    pulse_start(20'd42);
    wait_done(-1, 20'd0, lat, busy_ok, held_ok);
    chk("abort_next_lat", lat, 32'd20);
    chk("abort_next_bcd", {8'd0, bcd_out}, 32'h00000042);

    // Back-to-back: new start during the done cycle.
    @(negedge clk);
    pulse_start(20'd12345);
    wait_done(-1, 20'd0, lat, busy_ok, held_ok);
    chk("b2b_first_bcd", {8'd0, bcd_out}, 32'h00012345);
    pulse_start(20'd65536);
    chk("b2b_busy_rise", {31'd0, busy}, 32'd1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done(-1, 20'd0, lat, busy_ok, held_ok);
    chk("b2b_latency", lat, 32'd20);
    chk("b2b_held", {31'd0, held_ok}, 32'd1);
    chk("b2b_busy", {31'd0, busy_ok}, 32'd1);
    chk("b2b_second_bcd", {8'd0, bcd_out}, 32'h00065536);
    chk("b2b_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
